// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - segment constants shared by the seven-segment display driver
//
// Purpose: segment bit positions within the cathode byte, the active-low
//          hex-to-segment table and the blank pattern.
// Ports:   none (package).
package sevenseg_pkg;

  // Cathode byte layout is {a,b,c,d,e,f,g,dp}; all segments active-low.
  localparam int SEG_A  = 7;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Entry n holds the {a..g} pattern for hex digit n; listed F down to 0.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h38,  // F
    7'h30,  // E
    7'h42,  // d
    7'h31,  // C
    7'h60,  // b
    7'h08,  // A
    7'h04,  // 9
    7'h00,  // 8
    7'h0F,  // 7
    7'h20,  // 6
    7'h24,  // 5
    7'h4C,  // 4
    7'h06,  // 3
    7'h12,  // 2
    7'h4F,  // 1
    7'h01   // 0
  };

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - combinational nibble/dp/blank to active-low cathode byte
//
// Purpose: decodes one hex digit into the eight active-low cathode lines.
// Ports:   nibble_i  hex digit value
//          dp_i      decimal point, 1 = lit
//          blank_i   1 = force segments a-g off (dp unaffected)
//          cathode_o {a,b,c,d,e,f,g,dp}, active-low
module seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] cathode_o
);

  always_comb begin
    cathode_o              = 8'hFF;
    cathode_o[SEG_A:SEG_G] = blank_i ? SEG_BLANK : HEX_SEG_TABLE[nibble_i];
    cathode_o[SEG_DP]      = ~dp_i;
  end

endmodule

// File: rtl/sevenseg_mux_n.sv
// rtl/sevenseg_mux_n.sv - multiplexed N-digit seven-segment driver with shadowed load
//
// Purpose: scans DIGITS common-anode digits, one slot per 2^DIV_W clocks, with
//          leading-zero blanking, 16-level PWM brightness and a valid/ready
//          load port whose data commits only at a frame boundary.
// Ports:   clk          system clock
//          clr          asynchronous active-low reset
//          data_in      hex digits, nibble i drives anode[i]
//          dp_in        decimal point per digit
//          load/ready   load handshake for data_in/dp_in
//          lz_blank     1 = blank leading zeros
//          bright       PWM level, 15 = lit for the whole slot
//          enable       0 = all anodes off
//          cathode      {a..g,dp}, active-low, registered
//          anode        digit enables, active-low, registered
//          frame_start  one-cycle pulse as slot 0 begins, registered
module sevenseg_mux_n
  import sevenseg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DIV_W  = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic                  ready,
  input  logic                  lz_blank,
  input  logic [3:0]            bright,
  input  logic                  enable,
  output logic [7:0]            cathode,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_start
);

  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(DIGITS - 1);

  logic [DIV_W-1:0]    pre_q, pre_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] active_data_q, active_data_d;
  logic [DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]          cathode_q, cathode_d;
  logic                frame_start_q, frame_start_d;

  logic                pre_end;
  logic                frame_end;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic                pwm_on;

  assign ready = ~pending_q;

  // Prescaler, slot counter and the shadow/active handoff.
  always_comb begin
    pre_end   = &pre_q;
    frame_end = pre_end && (slot_q == LAST_SLOT);

    pre_d  = pre_q + DIV_W'(1);
    slot_d = slot_q;
    if (pre_end) begin
      slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
    end

    pending_d     = pending_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;

    // Commit looks only at the registered pending flag, so a load taken in
    // the boundary cycle itself waits for the next boundary.
    if (frame_end && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end

    if (load && !pending_q) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end
  end

  // Digit i is blanked when it and every digit to its left are zero;
  // digit 0 always shows so a zero value is never fully dark.
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    blank_vec = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (active_data_q[4*i +: 4] == 4'h0);
      blank_vec[i] = lz_blank && (i != 0) && all_zero;
    end
  end

  assign cur_nibble = active_data_q[{slot_q, 2'b00} +: 4];
  assign cur_dp     = active_dp_q[slot_q];
  assign pwm_on     = (pre_q[DIV_W-1 -: 4] <= bright);

  seg_decode u_seg_decode (
    .nibble_i  (cur_nibble),
    .dp_i      (cur_dp),
    .blank_i   (blank_vec[slot_q]),
    .cathode_o (cathode_d)
  );

  always_comb begin
    anode_d = '1;
    if (enable && pwm_on) begin
      anode_d[slot_q] = 1'b0;
    end
    frame_start_d = (slot_q == '0) && (pre_q == '0);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre_q         <= '0;
      slot_q        <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      pending_q     <= 1'b0;
      anode_q       <= '1;
      cathode_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      slot_q        <= slot_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      pending_q     <= pending_d;
      anode_q       <= anode_d;
      cathode_q     <= cathode_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign anode       = anode_q;
  assign cathode     = cathode_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// tb/tb_sevenseg_mux_n.sv - directed self-checking bench for sevenseg_mux_n
module tb_sevenseg_mux_n;

  logic        clk = 1'b0;
  logic        clr;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        ready;
  logic        lz_blank;
  logic [3:0]  bright;
  logic        enable;
  logic [7:0]  cathode;
  logic [3:0]  anode;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sevenseg_mux_n #(
    .DIGITS (4),
    .DIV_W  (4)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .data_in     (data_in),
    .dp_in       (dp_in),
    .load        (load),
    .ready       (ready),
    .lz_blank    (lz_blank),
    .bright      (bright),
    .enable      (enable),
    .cathode     (cathode),
    .anode       (anode),
    .frame_start (frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [7:0] ca);
    chk({tag, ".anode"}, 32'(anode), 32'(an));
    chk({tag, ".cathode"}, 32'(cathode), 32'(ca));
  endtask

  initial begin
    int       lows;
    logic [3:0] first_an;

    clr = 1'b0; load = 1'b0; data_in = '0; dp_in = '0;
    lz_blank = 1'b0; bright = 4'd15; enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 4'hF, 8'hFF);
    chk("reset.ready", 32'(ready), 1);
    chk("reset.fs", 32'(frame_start), 0);

    // Load 1208 in the first cycle after release; the display stays 0000
    // until the boundary at edge 64.
    clr = 1'b1; load = 1'b1; data_in = 16'h1208; dp_in = 4'h0;
    step();
    chk("c1.ready", 32'(ready), 0);
    chk("c1.fs", 32'(frame_start), 1);
    chk_out("c1", 4'hE, 8'h03);
    load = 1'b0; data_in = 16'hFFFF; dp_in = 4'hF;

    wait_to(64);
    chk_out("c64", 4'h7, 8'h03);
    chk("c64.ready", 32'(ready), 1);
    chk("c64.fs", 32'(frame_start), 0);
    wait_to(65);
    chk("c65.fs", 32'(frame_start), 1);
    chk_out("s0", 4'hE, 8'h01);
    wait_to(80);  chk_out("s0end", 4'hE, 8'h01);
    wait_to(81);  chk_out("s1", 4'hD, 8'h03);
    wait_to(97);  chk_out("s2", 4'hB, 8'h25);
    wait_to(113); chk_out("s3", 4'h7, 8'h9F);

    // Leading-zero blanking; second load while ready=0 must be ignored.
    lz_blank = 1'b1; load = 1'b1; data_in = 16'h0030; dp_in = 4'h0;
    step();
    chk("c114.ready", 32'(ready), 0);
    data_in = 16'h0000;
    step();
    load = 1'b0;
    wait_to(128); chk_out("c128", 4'h7, 8'h9F);
    chk("c128.ready", 32'(ready), 1);
    wait_to(129); chk_out("lz.s0", 4'hE, 8'h03);
    wait_to(145); chk_out("lz.s1", 4'hD, 8'h0D);
    wait_to(161); chk_out("lz.s2", 4'hB, 8'hFF);
    wait_to(177); chk_out("lz.s3", 4'h7, 8'hFF);

    // Load in the boundary cycle itself: commits one full frame later.
    wait_to(191);
    chk("c191.ready", 32'(ready), 1);
    load = 1'b1; data_in = 16'h0000;
    step();
    chk("c192.ready", 32'(ready), 0);
    load = 1'b0;
    wait_to(193); chk_out("bnd.s0", 4'hE, 8'h03);
    wait_to(209); chk_out("bnd.s1", 4'hD, 8'h0D);
    wait_to(256); chk("c256.ready", 32'(ready), 1);
    wait_to(257); chk_out("z.s0", 4'hE, 8'h03);
    wait_to(273); chk_out("z.s1", 4'hD, 8'hFF);

    // PWM: bright=0, bright=15, enable=0 over one slot each.
    bright = 4'd0;
    wait_to(288);
    lows = 0; first_an = 4'h0;
    repeat (16) begin
      step();
      if (cyc == 289) first_an = anode;
      if (anode != 4'hF) lows++;
    end
    chk("pwm0.lows", 32'(lows), 1);
    chk("pwm0.first", 32'(first_an), 32'hB);
    bright = 4'd15;
    lows = 0;
    repeat (16) begin
      step();
      if (anode == 4'h7) lows++;
    end
    chk("pwm15.lows", 32'(lows), 16);
    enable = 1'b0;
    lows = 0;
    repeat (16) begin
      step();
      if (anode != 4'hF) lows++;
    end
    chk("en0.lows", 32'(lows), 0);
    enable = 1'b1;

    // Reset with a pending load mid-slot: load discarded.
    wait_to(340);
    load = 1'b1; data_in = 16'hABCD; dp_in = 4'hF;
    step();
    chk("c341.ready", 32'(ready), 0);
    load = 1'b0;
    #2 clr = 1'b0;
    #1;
    chk_out("clr", 4'hF, 8'hFF);
    chk("clr.ready", 32'(ready), 1);
    chk("clr.fs", 32'(frame_start), 0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    cyc = 0;
    step();
    chk("rel.fs", 32'(frame_start), 1);
    chk("rel.ready", 32'(ready), 1);
    chk_out("rel.s0", 4'hE, 8'h03);
    wait_to(17); chk_out("rel.s1", 4'hD, 8'hFF);
    wait_to(65); chk_out("rel.f1", 4'hE, 8'h03);
    chk("rel.f1.fs", 32'(frame_start), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
